// File: rtl/buffer2_write_packer_pkg.sv
// Shared definitions for the line-buffer write packer.
//   state_e      : FSM encoding (FILL = collecting words, FULL = frame held)
//   DEF_*        : default geometry (16-bit words, 8-word buffer, 2 words/write)
//   addr_width   : buffer address width derived from the buffer depth
//   lane_width   : width of the pack-lane index
//   geometry_ok  : elaboration check that the depth is a whole number of groups
package buffer2_write_packer_pkg;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } state_e;

  localparam int DEF_SIZE      = 16;
  localparam int DEF_MEM_SIZE  = 8;
  localparam int DEF_PAR_WRITE = 2;

  function automatic int addr_width(input int mem_size);
    return (mem_size > 1) ? $clog2(mem_size) : 1;
  endfunction

  function automatic int lane_width(input int par_write);
    return (par_write > 1) ? $clog2(par_write) : 1;
  endfunction

  function automatic bit geometry_ok(input int mem_size, input int par_write);
    return (par_write >= 1) && (mem_size >= par_write) && ((mem_size % par_write) == 0);
  endfunction

endpackage

// File: rtl/buffer2_write_packer_if.sv
// Bundle of the packer's stream input, buffer write port and frame status.
//   in_valid/in_data/in_ready : upstream word handshake
//   wen/waddr/din             : wide write into the line buffer
//   buf_full/word_count       : frame status towards the consumer
//   frame_release             : consumer done with the frame ("release" is an
//                               SV keyword, hence the longer name)
// slave  : the packer's view; master : the upstream/consumer view.
interface buffer2_write_packer_if #(
  parameter int SIZE        = 16,
  parameter int PAR_WRITE   = 2,
  parameter int ADDRES_SIZE = 3
);
  logic                      in_valid;
  logic [SIZE-1:0]           in_data;
  logic                      in_ready;
  logic                      wen;
  logic [ADDRES_SIZE-1:0]    waddr;
  logic [SIZE*PAR_WRITE-1:0] din;
  logic                      buf_full;
  logic                      frame_release;
  logic [ADDRES_SIZE:0]      word_count;

  modport slave (
    input  in_valid, in_data, frame_release,
    output in_ready, wen, waddr, din, buf_full, word_count
  );

  modport master (
    output in_valid, in_data, frame_release,
    input  in_ready, wen, waddr, din, buf_full, word_count
  );
endinterface

// File: rtl/buffer2_write_packer_word_packer.sv
// Collects PAR_WRITE consecutive accepted words into one wide group.
//   clk, rst_n  : clock, synchronous active-low reset (drops a partial group)
//   accept      : a word is taken this cycle
//   data        : the word being taken
//   group_done  : this accept fills the last lane
//   group_data  : all lanes including the word being taken now, lane 0 lowest
module word_packer
  import buffer2_write_packer_pkg::*;
#(
  parameter int SIZE      = DEF_SIZE,
  parameter int PAR_WRITE = DEF_PAR_WRITE,
  parameter int LANE_W    = lane_width(PAR_WRITE)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      accept,
  input  logic [SIZE-1:0]           data,
  output logic                      group_done,
  output logic [SIZE*PAR_WRITE-1:0] group_data
);

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PAR_WRITE - 1);

  logic [LANE_W-1:0]         lane_q;
  logic [SIZE*PAR_WRITE-1:0] lanes_q;

  assign group_done = accept && (lane_q == LAST_LANE);

  // The completing word is merged combinationally so the top can register
  // the whole group on the same edge that accepts the last word.
  always_comb begin
    group_data = lanes_q;
    group_data[int'(lane_q)*SIZE +: SIZE] = data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lane_q  <= '0;
      lanes_q <= '0;
    end else if (accept) begin
      lanes_q[int'(lane_q)*SIZE +: SIZE] <= data;
      lane_q <= group_done ? '0 : lane_q + 1'b1;
    end
  end

endmodule

// File: rtl/buffer2_write_packer.sv
// Fill stage for the parallel-word line buffer: packs the serial word stream
// into PAR_WRITE-word writes at ascending addresses, flags the buffer full
// after the last write has landed, and stalls until the consumer releases.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : stream input, buffer write port and frame status (slave view)
//
// state | meaning
// FILL  | accepting words, committing a group per PAR_WRITE accepts
// FULL  | frame complete; stream stalled until frame_release with buf_full=1
module buffer2_write_packer
  import buffer2_write_packer_pkg::*;
#(
  parameter int SIZE        = DEF_SIZE,
  parameter int MEM_SIZE    = DEF_MEM_SIZE,
  parameter int PAR_WRITE   = DEF_PAR_WRITE,
  parameter int ADDRES_SIZE = addr_width(MEM_SIZE)
) (
  input logic                   clk,
  input logic                   rst_n,
  buffer2_write_packer_if.slave bus
);

  if (!geometry_ok(MEM_SIZE, PAR_WRITE)) begin : g_geometry_check
    $error("buffer2_write_packer: MEM_SIZE must be a non-zero multiple of PAR_WRITE");
  end

  localparam logic [ADDRES_SIZE-1:0] LAST_BASE = ADDRES_SIZE'(MEM_SIZE - PAR_WRITE);
  localparam logic [ADDRES_SIZE-1:0] STEP      = ADDRES_SIZE'(PAR_WRITE);
  localparam logic [ADDRES_SIZE:0]   STEP_CNT  = (ADDRES_SIZE+1)'(PAR_WRITE);

  state_e                    state_q, state_d;
  logic                      in_ready_q, in_ready_d;
  logic                      wen_q, wen_d;
  logic [ADDRES_SIZE-1:0]    waddr_q, waddr_d;
  logic [SIZE*PAR_WRITE-1:0] din_q, din_d;
  logic                      buf_full_q, buf_full_d;
  logic [ADDRES_SIZE-1:0]    base_q, base_d;
  logic [ADDRES_SIZE:0]      word_count_q, word_count_d;

  logic                      accept;
  logic                      group_done;
  logic [SIZE*PAR_WRITE-1:0] group_data;

  assign accept = bus.in_valid && in_ready_q && (state_q == ST_FILL);

  word_packer #(
    .SIZE      (SIZE),
    .PAR_WRITE (PAR_WRITE)
  ) u_word_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .accept     (accept),
    .data       (bus.in_data),
    .group_done (group_done),
    .group_data (group_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_FILL;
      in_ready_q   <= 1'b0;
      wen_q        <= 1'b0;
      waddr_q      <= '0;
      din_q        <= '0;
      buf_full_q   <= 1'b0;
      base_q       <= '0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      wen_q        <= wen_d;
      waddr_q      <= waddr_d;
      din_q        <= din_d;
      buf_full_q   <= buf_full_d;
      base_q       <= base_d;
      word_count_q <= word_count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    in_ready_d   = in_ready_q;
    wen_d        = 1'b0;
    waddr_d      = waddr_q;
    din_d        = din_q;
    buf_full_d   = buf_full_q;
    base_d       = base_q;
    word_count_d = word_count_q;

    unique case (state_q)
      ST_FILL: begin
        in_ready_d = 1'b1;
        if (group_done) begin
          wen_d        = 1'b1;
          waddr_d      = base_q;
          din_d        = group_data;
          word_count_d = {1'b0, base_q} + STEP_CNT;
          if (base_q == LAST_BASE) begin
            // base stays on the last group so it never leaves the address range
            state_d    = ST_FULL;
            in_ready_d = 1'b0;
          end else begin
            base_d = base_q + STEP;
          end
        end
      end
      ST_FULL: begin
        in_ready_d = 1'b0;
        // Entered with the final wen still pending; full is raised one cycle
        // later so the buffer already holds the last group.
        buf_full_d = 1'b1;
        if (buf_full_q && bus.frame_release) begin
          state_d      = ST_FILL;
          in_ready_d   = 1'b1;
          buf_full_d   = 1'b0;
          base_d       = '0;
          word_count_d = '0;
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.wen        = wen_q;
  assign bus.waddr      = waddr_q;
  assign bus.din        = din_q;
  assign bus.buf_full   = buf_full_q;
  assign bus.word_count = word_count_q;

endmodule
